// File: rtl/echo_capture.sv
// echo_capture: synchronised, glitch-filtered, ring-down-blanked ultrasonic time-of-flight capture
module echo_capture #(
    parameter int BLANK_CYC   = 50000,
    parameter int TIMEOUT_CYC = 3000000,
    parameter int FILT_LEN    = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             burst_start,
    input  logic             receive,
    output logic [CNT_W-1:0] tof,
    output logic             tof_valid,
    output logic             timeout,
    output logic             busy,
    output logic             echo_seen
);
    localparam int RW = $clog2(FILT_LEN + 1);
    typedef enum logic [1:0] {IDLE, BLANK, LISTEN} state_t;
    state_t state, state_n;
    logic s1, rx_s, filt_d, filt, qual, hit, expire;
    logic [RW-1:0] run;
    logic [CNT_W-1:0] cnt;
    assign filt   = run == RW'(FILT_LEN);
    assign qual   = filt & ~filt_d;
    assign busy   = state != IDLE;
    assign hit    = state == LISTEN && qual && !burst_start;
    assign expire = state == LISTEN && !qual && cnt == CNT_W'(TIMEOUT_CYC) && !burst_start;
    always_comb begin
        state_n = state;
        state_n = burst_start ? BLANK :
                  (state == BLANK && cnt == CNT_W'(BLANK_CYC - 1)) ? LISTEN :
                  (hit || expire) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b0;
            rx_s      <= 1'b0;
            run       <= '0;
            filt_d    <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            tof       <= '0;
            tof_valid <= 1'b0;
            timeout   <= 1'b0;
            echo_seen <= 1'b0;
        end else begin
            s1        <= receive;
            rx_s      <= s1;
            run       <= !rx_s ? '0 : filt ? run : run + RW'(1);
            filt_d    <= filt;
            state     <= state_n;
            cnt       <= burst_start ? CNT_W'(1) : (busy && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
            tof       <= hit ? cnt : tof;
            tof_valid <= hit;
            timeout   <= expire;
            echo_seen <= burst_start ? 1'b0 : hit ? 1'b1 : echo_seen;
        end
    end
endmodule

// File: tb/tb_echo_capture.sv
// tb_echo_capture: scoreboard bench; tests push expected pulses, a monitor pops and compares them
module tb_echo_capture;
    logic clk = 1'b0, rst, burst_start, receive;
    logic [31:0] tof;
    logic tof_valid, timeout, busy, echo_seen;
    int n_run = 0, n_fail = 0, cyc = -100;
    typedef struct { bit is_to; int cyc; logic [31:0] tof; } ev_t;
    ev_t sb[$];
    ev_t e;

    echo_capture #(.BLANK_CYC(100), .TIMEOUT_CYC(1000), .FILT_LEN(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .burst_start(burst_start), .receive(receive),
        .tof(tof), .tof_valid(tof_valid), .timeout(timeout), .busy(busy), .echo_seen(echo_seen)
    );

    always #5 clk = ~clk;

    // cycle numbers are relative to the burst; cyc names the cycle whose outputs are visible after the edge
    always @(posedge clk) begin
        #1;
        if (tof_valid || timeout) begin
            n_run++;
            if (tof_valid && timeout) begin
                n_fail++;
                $display("FAIL both_pulses cyc=%0d got tof_valid=1 timeout=1 want at most one", cyc);
            end else if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse cyc=%0d got tof_valid=%b timeout=%b want none", cyc, tof_valid, timeout);
            end else begin
                e = sb.pop_front();
                if (timeout !== e.is_to || cyc !== e.cyc || tof !== e.tof) begin
                    n_fail++;
                    $display("FAIL pulse got timeout=%b cyc=%0d tof=%0d want timeout=%b cyc=%0d tof=%0d",
                             timeout, cyc, tof, e.is_to, e.cyc, e.tof);
                end
            end
        end
    end

    task automatic drive(input int c, input logic b, input logic x, input logic r);
        @(negedge clk);
        cyc = c + 1;
        burst_start = b;
        receive = x;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        for (int i = 0; i < 6; i++) drive(-100, 1'b0, 1'b0, 1'b0);
        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pulses got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        drive(-100, 1'b1, 1'b1, 1'b1);
        drive(-100, 1'b0, 1'b0, 1'b1);
        n_run += 5;
        if (tof !== 32'd0) begin n_fail++; $display("FAIL reset_tof got %0d want 0", tof); end
        if (tof_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tof_valid got %b want 0", tof_valid); end
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (echo_seen !== 1'b0) begin n_fail++; $display("FAIL reset_echo_seen got %b want 0", echo_seen); end
        settle();
    endtask

    task automatic test_glitch();
        sb.push_back('{1'b0, 407, 32'd406});
        for (int c = 0; c <= 420; c++) begin
            drive(c, c == 0, (c >= 200 && c <= 202) || c >= 400, 1'b0);
            if (cyc == 1) begin
                n_run++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy got %b want 1", busy); end
            end
        end
        settle();
    endtask

    task automatic test_ringdown();
        sb.push_back('{1'b1, 1001, 32'd406});
        for (int c = 0; c <= 1010; c++) begin
            drive(c, c == 0, c >= 10, 1'b0);
            if (cyc == 1001) begin
                n_run += 2;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL ringdown_busy got %b want 0", busy); end
                if (echo_seen !== 1'b0) begin n_fail++; $display("FAIL ringdown_echo_seen got %b want 0", echo_seen); end
            end
        end
        settle();
    endtask

    task automatic test_echo();
        sb.push_back('{1'b0, 307, 32'd306});
        for (int c = 0; c <= 320; c++) begin
            drive(c, c == 0, c >= 300, 1'b0);
            if (cyc == 306) begin
                n_run += 2;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL echo_busy_before got %b want 1", busy); end
                if (echo_seen !== 1'b0) begin n_fail++; $display("FAIL echo_seen_before got %b want 0", echo_seen); end
            end
            if (cyc == 307) begin
                n_run += 3;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL echo_busy_after got %b want 0", busy); end
                if (echo_seen !== 1'b1) begin n_fail++; $display("FAIL echo_seen_after got %b want 1", echo_seen); end
                if (tof !== 32'd306) begin n_fail++; $display("FAIL echo_tof got %0d want 306", tof); end
            end
        end
        settle();
    endtask

    task automatic test_timeout();
        sb.push_back('{1'b1, 1001, 32'd306});
        for (int c = 0; c <= 1010; c++) begin
            drive(c, c == 0, 1'b0, 1'b0);
            if (cyc == 2) begin
                n_run++;
                if (echo_seen !== 1'b0) begin n_fail++; $display("FAIL timeout_seen_cleared got %b want 0", echo_seen); end
            end
        end
        n_run++;
        if (tof !== 32'd306) begin n_fail++; $display("FAIL timeout_tof got %0d want 306", tof); end
        settle();
    endtask

    task automatic test_restart();
        sb.push_back('{1'b0, 707, 32'd206});
        for (int c = 0; c <= 720; c++) begin
            drive(c, c == 0 || c == 500, c >= 700, 1'b0);
            if (cyc == 501) begin
                n_run++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got %b want 1", busy); end
            end
        end
        settle();
    endtask

    task automatic test_qual_at_timeout();
        sb.push_back('{1'b0, 1001, 32'd1000});
        for (int c = 0; c <= 1010; c++) drive(c, c == 0, c >= 994, 1'b0);
        settle();
    endtask

    task automatic test_restart_on_qual();
        sb.push_back('{1'b1, 1307, 32'd1000});
        for (int c = 0; c <= 1320; c++) begin
            drive(c, c == 0 || c == 306, c >= 300, 1'b0);
            if (cyc == 307) begin
                n_run += 2;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL rq_busy got %b want 1", busy); end
                if (tof !== 32'd1000) begin n_fail++; $display("FAIL rq_tof got %0d want 1000", tof); end
            end
        end
        settle();
    endtask

    task automatic test_rst_mid();
        for (int c = 0; c <= 2000; c++) begin
            drive(c, c == 0, c >= 300, c == 200);
            if (cyc == 201) begin
                n_run += 2;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
                if (tof !== 32'd0) begin n_fail++; $display("FAIL rst_tof got %0d want 0", tof); end
            end
        end
        n_run += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_end got %b want 0", busy); end
        if (echo_seen !== 1'b0) begin n_fail++; $display("FAIL rst_echo_seen got %b want 0", echo_seen); end
        settle();
    endtask

    initial begin
        rst = 1'b1;
        burst_start = 1'b0;
        receive = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_glitch();
        test_ringdown();
        test_echo();
        test_timeout();
        test_restart();
        test_qual_at_timeout();
        test_restart_on_qual();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
